dpll_loop_ctrl: RTL and testbench

DPLL_LOOP_CTRL -- requirements
Module: dpll_loop_ctrl

---
 rtl/dpll_loop_ctrl_if.sv | 23 ++
 rtl/dpll_loop_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dpll_loop_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dpll_loop_ctrl_if.sv
// rtl/dpll_loop_ctrl_if.sv - phase-detector inputs and counter-pulse outputs of the DPLL loop controller
interface dpll_loop_ctrl_if #(
  parameter int K_W = 4
);
  logic           en;
  logic           pd_lead;
  logic           pd_lag;
  logic [K_W-1:0] k_sel;
  logic           inc;
  logic           dec;
  logic           locked;
  logic           busy;

  modport master (
    output en, pd_lead, pd_lag, k_sel,
    input  inc, dec, locked, busy
  );

  modport slave (
    input  en, pd_lead, pd_lag, k_sel,
    output inc, dec, locked, busy
  );
endinterface

// File: rtl/dpll_loop_ctrl.sv
// rtl/dpll_loop_ctrl.sv - DPLL random-walk loop filter with IDLE/TRACK/HOLDOFF sequencing
// Lock detector is built only when DPLL_LOOP_CTRL_LOCK_EN is defined; otherwise locked is tied low.
module dpll_loop_ctrl #(
  parameter int K_W         = 4,
  parameter int HOLDOFF     = 4,
  parameter int LOCK_W      = 8,
  parameter int LOCK_THRESH = 200
) (
  input logic             clk,
  input logic             reset,
  dpll_loop_ctrl_if.slave lp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Two extra bits: sign plus headroom for acc +/- 1 around the +/-K limits.
  localparam int AW = K_W + 2;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [1:0]           state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [K_W-1:0]       k_lat_q, k_lat_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 inc_q, inc_d;
  logic                 dec_q, dec_d;
  logic                 busy_q, busy_d;

  logic signed [AW-1:0] step;
  logic signed [AW-1:0] acc_step;
  logic signed [AW-1:0] k_pos;
  logic signed [AW-1:0] k_neg;
  logic signed [AW-1:0] lim_pos;
  logic signed [AW-1:0] lim_neg;

  always_comb begin
    step = '0;
    if (lp.pd_lead && !lp.pd_lag) begin
      step = AW'(1);
    end else if (lp.pd_lag && !lp.pd_lead) begin
      step = '1;
    end
  end

  assign acc_step = acc_q + step;
  assign k_pos    = $signed({2'b00, k_lat_q});
  assign k_neg    = -k_pos;
  assign lim_pos  = k_pos - AW'(1);
  assign lim_neg  = -lim_pos;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_lat_d = k_lat_q;
    hold_d  = hold_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    if (!lp.en) begin
      state_d = S_IDLE;
      acc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          acc_d   = '0;
          k_lat_d = (lp.k_sel == '0) ? K_W'(1) : lp.k_sel;
          state_d = S_TRACK;
        end
        S_TRACK: begin
          if (acc_step == k_pos) begin
            inc_d   = 1'b1;
            acc_d   = '0;
            hold_d  = HOLDOFF[HW-1:0];
            state_d = S_HOLD;
          end else if (acc_step == k_neg) begin
            dec_d   = 1'b1;
            acc_d   = '0;
            hold_d  = HOLDOFF[HW-1:0];
            state_d = S_HOLD;
          end else begin
            acc_d = acc_step;
          end
        end
        S_HOLD: begin
          // Keep walking but stay one step short of a pulse until TRACK resumes.
          if (acc_step > lim_pos) begin
            acc_d = lim_pos;
          end else if (acc_step < lim_neg) begin
            acc_d = lim_neg;
          end else begin
            acc_d = acc_step;
          end
          if (hold_q == '0) begin
            state_d = S_TRACK;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
        end
      endcase
    end
    // The pulse cycle itself is not counted as busy; only the quiet cycles after it.
    busy_d = (state_d == S_HOLD) && !(inc_d || dec_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_lat_q <= K_W'(1);
      hold_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_lat_q <= k_lat_d;
      hold_q  <= hold_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
    end
  end

  assign lp.inc  = inc_q;
  assign lp.dec  = dec_q;
  assign lp.busy = busy_q;

`ifdef DPLL_LOOP_CTRL_LOCK_EN
  localparam logic [LOCK_W-1:0] LOCK_TH = LOCK_THRESH[LOCK_W-1:0];

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lp.en || state_q == S_IDLE || inc_d || dec_d) begin
      lock_cnt_d = '0;
    end else if (state_q == S_TRACK && lock_cnt_q != '1) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
    locked_d = (lock_cnt_d >= LOCK_TH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign lp.locked = locked_q;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_W, LOCK_THRESH};
  assign lp.locked       = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// tb/tb_dpll_loop_ctrl.sv - directed and randomized checks of dpll_loop_ctrl against a behavioural model
module tb_dpll_loop_ctrl;

  localparam int K_W         = 4;
  localparam int HOLDOFF     = 4;
  localparam int LOCK_W      = 8;
  localparam int LOCK_THRESH = 200;
  localparam int LOCK_MAX    = (1 << LOCK_W) - 1;
`ifdef DPLL_LOOP_CTRL_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic clk;
  logic reset;

  dpll_loop_ctrl_if #(.K_W(K_W)) bus ();

  dpll_loop_ctrl #(
    .K_W(K_W), .HOLDOFF(HOLDOFF), .LOCK_W(LOCK_W), .LOCK_THRESH(LOCK_THRESH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .lp   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int { M_OFF, M_WALK, M_REST } mode_t;

  mode_t m_mode;
  int    m_acc, m_k, m_rest_left, m_lock;
  bit    x_inc, x_dec, x_busy, x_locked;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int inc_seen, dec_seen;
  int pulse_cycles[$];

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural view of one clock edge, phrased in terms of walk/rest periods.
  task automatic model_edge(input bit r, input bit e, input bit l, input bit g, input int ks);
    int d;
    int lim;
    d = (l && !g) ? 1 : ((g && !l) ? -1 : 0);
    x_inc  = 1'b0;
    x_dec  = 1'b0;
    x_busy = 1'b0;
    if (r) begin
      m_mode = M_OFF; m_acc = 0; m_k = 1; m_lock = 0;
    end else if (!e) begin
      m_mode = M_OFF; m_acc = 0; m_lock = 0;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_k = (ks == 0) ? 1 : ks;
          m_acc = 0; m_lock = 0; m_mode = M_WALK;
        end
        M_WALK: begin
          if (m_acc + d == m_k || m_acc + d == -m_k) begin
            x_inc = (d > 0); x_dec = (d < 0);
            m_acc = 0; m_lock = 0; m_rest_left = HOLDOFF; m_mode = M_REST;
          end else begin
            m_acc = m_acc + d;
            if (m_lock < LOCK_MAX) m_lock = m_lock + 1;
          end
        end
        default: begin
          lim = m_k - 1;
          m_acc = m_acc + d;
          if (m_acc > lim) m_acc = lim;
          if (m_acc < -lim) m_acc = -lim;
          if (m_rest_left > 0) begin
            x_busy = 1'b1;
            m_rest_left = m_rest_left - 1;
          end else begin
            m_mode = M_WALK;
          end
        end
      endcase
    end
    x_locked = LOCK_ON && (m_lock >= LOCK_THRESH);
  endtask

  task automatic tick(input bit r, input bit e, input bit l, input bit g, input int ks);
    logic [31:0] kv;
    kv = ks;
    reset       = r;
    bus.en      = e;
    bus.pd_lead = l;
    bus.pd_lag  = g;
    bus.k_sel   = kv[K_W-1:0];
    @(posedge clk);
    model_edge(r, e, l, g, ks);
    #1;
    cyc++;
    check("inc", bus.inc, x_inc);
    check("dec", bus.dec, x_dec);
    check("busy", bus.busy, x_busy);
    check("locked", bus.locked, x_locked);
    check("inc_dec_exclusive", bus.inc & bus.dec, 1'b0);
    if (bus.inc) begin
      inc_seen++;
      pulse_cycles.push_back(cyc);
    end
    if (bus.dec) dec_seen++;
  endtask

  initial begin
    int pl, pg, r, e, ks;
    m_mode = M_OFF; m_acc = 0; m_k = 1; m_rest_left = 0; m_lock = 0;
    reset = 1'b1; bus.en = 1'b0; bus.pd_lead = 1'b0; bus.pd_lag = 1'b0; bus.k_sel = '0;

    // Reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 7);
    check("reset_inc", bus.inc, 1'b0);
    check("reset_busy", bus.busy, 1'b0);

    // K=3, three lead samples then one pulse and four busy cycles
    tick(0, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 3);
    check("k3_inc_after_third", bus.inc, 1'b1);
    check("k3_no_dec", bus.dec, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0, 3);
      check("k3_busy_window", bus.busy, 1'b1);
    end
    tick(0, 1, 0, 0, 3);
    check("k3_busy_end", bus.busy, 1'b0);

    // K=2, lead held: pulse spacing 1 + HOLDOFF + 1
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 2);
    pulse_cycles.delete();
    for (int i = 0; i < 30; i++) tick(0, 1, 1, 0, 2);
    check_int("k2_pulse_count_min", (pulse_cycles.size() >= 4) ? 1 : 0, 1);
    for (int i = 1; i < pulse_cycles.size(); i++)
      check_int("k2_pulse_spacing", pulse_cycles[i] - pulse_cycles[i-1], 2 + HOLDOFF);

    // K=4, alternating lead/lag then both: never a pulse
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 4);
    inc_seen = 0; dec_seen = 0;
    for (int i = 0; i < 20; i++) tick(0, 1, (i % 2) == 0, (i % 2) == 1, 4);
    for (int i = 0; i < 20; i++) tick(0, 1, 1, 1, 4);
    check_int("k4_no_pulses", inc_seen + dec_seen, 0);

    // K=5, quiet for LOCK_THRESH cycles, then five lag samples
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 5);
    for (int i = 0; i < LOCK_THRESH - 1; i++) tick(0, 1, 0, 0, 5);
    check("lock_before_thresh", bus.locked, 1'b0);
    tick(0, 1, 0, 0, 5);
    check("lock_at_thresh", bus.locked, LOCK_ON);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 1, 5);
    check("k5_dec_pulse", bus.dec, 1'b1);
    check("k5_lock_drop", bus.locked, 1'b0);

    // en dropped mid-HOLDOFF with acc=+2, re-enabled with k_sel=0
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 5);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 0, 5);
    check("k5_inc_pulse", bus.inc, 1'b1);
    tick(0, 1, 1, 0, 5);
    tick(0, 1, 1, 0, 5);
    check_int("model_acc_two", m_acc, 2);
    tick(0, 0, 0, 0, 0);
    check("en_low_busy", bus.busy, 1'b0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 0);
    check("k0_first_lag_dec", bus.dec, 1'b1);

    // reset during the pulse cycle
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    tick(0, 1, 1, 0, 1);
    check("k1_inc", bus.inc, 1'b1);
    tick(1, 1, 1, 0, 1);
    check("reset_mid_pulse_inc", bus.inc, 1'b0);
    check("reset_mid_pulse_busy", bus.busy, 1'b0);
    tick(0, 1, 1, 0, 9);
    tick(0, 1, 1, 0, 9);
    check("after_reset_no_pulse_yet", bus.inc, 1'b0);

    // Randomized traffic against the model
    pl = 50; pg = 50;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 64) == 0) begin
        pl = $urandom_range(0, 100);
        pg = $urandom_range(0, 100);
      end
      r  = ($urandom_range(0, 199) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 39) != 0) ? 1 : 0;
      ks = $urandom_range(0, (1 << K_W) - 1);
      tick(r[0], e[0], $urandom_range(0, 99) < pl, $urandom_range(0, 99) < pg, ks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
